// File: rtl/iir_biquad_cascade.sv
// Cascade of NSEC direct-form-II biquads sharing one multiply-accumulate.
// Each section takes 5 MAC cycles: two feedback taps form w, three
// feed-forward taps form y. Coefficients are writable while idle.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready is high only in IDLE. out_valid stays
// high with out_data held until out_ready is seen.
module iir_biquad_cascade #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14,
  parameter int NSEC = 4,
  parameter int ACCW = 40,
  localparam int SW  = (NSEC > 1) ? $clog2(NSEC) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          coef_we,
  input  logic [SW-1:0] coef_sec,
  input  logic [2:0]    coef_idx,
  input  logic [CW-1:0] coef_wdata,
  input  logic          clear_state,
  output logic          busy,
  output logic          sat_flag
);

  typedef enum logic [1:0] {IDLE, CALC, OUTS} state_t;

  localparam logic [CW-1:0]          COEF_ONE = CW'(1 << FRAC);
  localparam logic [SW:0]            NSEC_W   = (SW+1)'(NSEC);
  localparam logic [SW-1:0]          LAST_SEC = SW'(NSEC - 1);
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t state, state_nxt;

  logic signed [CW-1:0]   b0_r [NSEC];
  logic signed [CW-1:0]   b1_r [NSEC];
  logic signed [CW-1:0]   b2_r [NSEC];
  logic signed [CW-1:0]   a1_r [NSEC];
  logic signed [CW-1:0]   a2_r [NSEC];
  logic signed [DW-1:0]   w1_r [NSEC];
  logic signed [DW-1:0]   w2_r [NSEC];

  logic [SW-1:0]          sec;
  logic [2:0]             tap;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   x_reg;
  logic signed [DW-1:0]   w_reg;

  logic signed [CW-1:0]    coef_sel;
  logic signed [DW-1:0]    data_sel;
  logic signed [CW+DW-1:0] prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  x_ext;
  logic signed [ACCW-1:0]  acc_nxt;
  logic signed [ACCW-1:0]  shifted;
  logic signed [DW-1:0]    sat_val;
  logic                    clamp;
  logic                    last_tap;
  logic                    coef_ok;

  assign last_tap = (tap == 3'd4) && (sec == LAST_SEC);
  assign coef_ok  = coef_we && (coef_idx <= 3'd4) && ({1'b0, coef_sec} < NSEC_W);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_tap) state_nxt = OUTS;
      end
      OUTS: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand selection for the shared multiplier, by tap.
  always_comb begin
    coef_sel = '0;
    data_sel = '0;
    case (tap)
      3'd0:    begin coef_sel = a1_r[sec]; data_sel = w1_r[sec]; end
      3'd1:    begin coef_sel = a2_r[sec]; data_sel = w2_r[sec]; end
      3'd2:    begin coef_sel = b0_r[sec]; data_sel = w_reg;     end
      3'd3:    begin coef_sel = b1_r[sec]; data_sel = w1_r[sec]; end
      default: begin coef_sel = b2_r[sec]; data_sel = w2_r[sec]; end
    endcase
  end

  // Accumulator update, rescale and saturation.
  always_comb begin
    prod     = coef_sel * data_sel;
    prod_ext = {{(ACCW-CW-DW){prod[CW+DW-1]}}, prod};
    x_ext    = {{(ACCW-DW){x_reg[DW-1]}}, x_reg} <<< FRAC;
    case (tap)
      3'd0:    acc_nxt = x_ext - prod_ext;
      3'd1:    acc_nxt = acc - prod_ext;
      3'd2:    acc_nxt = prod_ext;
      default: acc_nxt = acc + prod_ext;
    endcase
    shifted = acc_nxt >>> FRAC;
    clamp   = 1'b0;
    sat_val = shifted[DW-1:0];
    if (shifted > SMAX) begin
      sat_val = SMAX[DW-1:0];
      clamp   = 1'b1;
    end else if (shifted < SMIN) begin
      sat_val = SMIN[DW-1:0];
      clamp   = 1'b1;
    end
  end

  // Coefficients, delay lines and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEC; i++) begin
        b0_r[i] <= COEF_ONE;
        b1_r[i] <= '0;
        b2_r[i] <= '0;
        a1_r[i] <= '0;
        a2_r[i] <= '0;
        w1_r[i] <= '0;
        w2_r[i] <= '0;
      end
      sec      <= '0;
      tap      <= '0;
      acc      <= '0;
      x_reg    <= '0;
      w_reg    <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_ok) begin
            case (coef_idx)
              3'd0:    b0_r[coef_sec] <= coef_wdata;
              3'd1:    b1_r[coef_sec] <= coef_wdata;
              3'd2:    b2_r[coef_sec] <= coef_wdata;
              3'd3:    a1_r[coef_sec] <= coef_wdata;
              default: a2_r[coef_sec] <= coef_wdata;
            endcase
          end
          if (clear_state) begin
            for (int i = 0; i < NSEC; i++) begin
              w1_r[i] <= '0;
              w2_r[i] <= '0;
            end
          end
          if (in_valid) begin
            x_reg <= in_data;
            sec   <= '0;
            tap   <= '0;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (tap == 3'd1) begin
            w_reg <= sat_val;
            if (clamp) sat_flag <= 1'b1;
          end
          if (tap == 3'd4) begin
            w2_r[sec] <= w1_r[sec];
            w1_r[sec] <= w_reg;
            x_reg     <= sat_val;
            if (clamp) sat_flag <= 1'b1;
            if (sec == LAST_SEC) out_data <= sat_val;
            sec <= sec + 1'b1;
            tap <= '0;
          end else begin
            tap <= tap + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Bench for iir_biquad_cascade: directed steps from the test plan followed
// by randomized coefficients and samples, checked against a plain
// arithmetic model of the cascade.
module tb_iir_biquad_cascade;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int FRAC = 14;
  localparam int NSEC = 4;
  localparam int ACCW = 40;
  localparam int SW   = 2;
  localparam int LAT  = 5 * NSEC + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          coef_we;
  logic [SW-1:0] coef_sec;
  logic [2:0]    coef_idx;
  logic [CW-1:0] coef_wdata;
  logic          clear_state;
  logic          busy;
  logic          sat_flag;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int mb0 [NSEC];
  int mb1 [NSEC];
  int mb2 [NSEC];
  int ma1 [NSEC];
  int ma2 [NSEC];
  int mw1 [NSEC];
  int mw2 [NSEC];
  bit m_sat;

  iir_biquad_cascade #(
    .DW(DW), .CW(CW), .FRAC(FRAC), .NSEC(NSEC), .ACCW(ACCW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_sec(coef_sec), .coef_idx(coef_idx),
    .coef_wdata(coef_wdata), .clear_state(clear_state),
    .busy(busy), .sat_flag(sat_flag)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < NSEC; s++) begin
      mb0[s] = 1 << FRAC; mb1[s] = 0; mb2[s] = 0; ma1[s] = 0; ma2[s] = 0;
      mw1[s] = 0; mw2[s] = 0;
    end
    m_sat = 0;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < NSEC; s++) begin
      mw1[s] = 0; mw2[s] = 0;
    end
  endfunction

  function automatic void model_write(input int sec, input int idx, input int val);
    if (sec < NSEC) begin
      case (idx)
        0: mb0[sec] = val;
        1: mb1[sec] = val;
        2: mb2[sec] = val;
        3: ma1[sec] = val;
        4: ma2[sec] = val;
        default: ;
      endcase
    end
  endfunction

  function automatic longint msat(input longint v);
    if (v > 32767) begin m_sat = 1; return 32767; end
    if (v < -32768) begin m_sat = 1; return -32768; end
    return v;
  endfunction

  function automatic int model_step(input int x);
    longint xin, w, y;
    xin = x;
    for (int s = 0; s < NSEC; s++) begin
      w = msat(((xin <<< FRAC) - longint'(ma1[s]) * mw1[s] - longint'(ma2[s]) * mw2[s]) >>> FRAC);
      y = msat((longint'(mb0[s]) * w + longint'(mb1[s]) * mw1[s] + longint'(mb2[s]) * mw2[s]) >>> FRAC);
      mw2[s] = mw1[s];
      mw1[s] = int'(w);
      xin = y;
    end
    return int'(xin);
  endfunction

  // Coefficient write while the block is idle.
  task automatic write_coef(input int sec, input int idx, input int val);
    @(negedge clk);
    coef_we = 1'b1; coef_sec = SW'(sec); coef_idx = 3'(idx); coef_wdata = CW'(val);
    model_write(sec, idx, val);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  // One sample through the block, with optional same-edge clear/write and
  // an optional stretch of output backpressure.
  task automatic send_sample(input int x, input bit use_lit, input int lit,
                             input bit clr, input bit wr, input int wsec,
                             input int widx, input int wval, input int hold);
    int exp_y;
    int cnt;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_data = DW'(x); in_valid = 1'b1; clear_state = clr;
    out_ready = (hold == 0);
    if (wr) begin
      coef_we = 1'b1; coef_sec = SW'(wsec); coef_idx = 3'(widx); coef_wdata = CW'(wval);
    end
    if (clr) model_clear();
    if (wr) model_write(wsec, widx, wval);
    exp_y = model_step(x);
    if (use_lit) exp_y = lit;
    @(posedge clk); #1;
    in_valid = 1'b0; clear_state = 1'b0; coef_we = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 3) chk("busy_calc", busy, 1);
    end while (!out_valid && cnt < 200);
    chk("latency", cnt, LAT);
    chk("out_data", $signed(out_data), exp_y);
    chk("sat_flag", sat_flag, m_sat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      coef_we = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_data", $signed(out_data), exp_y);
      if (i == 3) begin
        coef_we = 1'b1; coef_sec = 2'd0; coef_idx = 3'd0; coef_wdata = CW'(8192);
      end
    end
    if (hold > 0) begin
      @(negedge clk);
      coef_we = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    int cnt;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_sec = '0; coef_idx = '0; coef_wdata = '0; clear_state = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    // Pass-through after reset.
    send_sample(1000, 1, 1000, 0, 0, 0, 0, 0, 0);
    send_sample(-32768, 1, -32768, 0, 0, 0, 0, 0, 0);
    send_sample(32767, 1, 32767, 0, 0, 0, 0, 0, 0);

    // Gain of one half on section 0, floor truncation on negatives.
    write_coef(0, 0, 8192);
    send_sample(1000, 1, 500, 0, 0, 0, 0, 0, 0);
    send_sample(-1001, 1, -501, 0, 0, 0, 0, 0, 0);

    // Write committed on the same edge as the sample: sec1 gain 0.5 -> 0.25 overall.
    send_sample(400, 1, 100, 0, 1, 1, 0, 8192, 0);
    write_coef(0, 0, 16384);
    write_coef(1, 0, 16384);

    // First-order recursion w = x + 0.5*w1, then clear with same-edge sample.
    model_clear();
    send_sample(0, 0, 0, 1, 0, 0, 0, 0, 0);
    write_coef(0, 3, -8192);
    send_sample(16384, 1, 16384, 0, 0, 0, 0, 0, 0);
    send_sample(0, 1, 8192, 0, 0, 0, 0, 0, 0);
    send_sample(0, 1, 4096, 0, 0, 0, 0, 0, 0);
    send_sample(0, 1, 2048, 0, 0, 0, 0, 0, 0);
    send_sample(0, 1, 0, 1, 0, 0, 0, 0, 0);
    write_coef(0, 3, 0);

    // Saturation and sticky flag.
    write_coef(0, 0, 32767);
    send_sample(30000, 1, 32767, 0, 0, 0, 0, 0, 0);
    chk("sat_set", sat_flag, 1);
    write_coef(0, 0, 16384);
    send_sample(100, 1, 100, 0, 0, 0, 0, 0, 0);
    chk("sat_sticky", sat_flag, 1);

    // Backpressure with a dropped write during the wait.
    send_sample(-777, 1, -777, 0, 0, 0, 0, 0, 10);
    send_sample(200, 1, 200, 0, 0, 0, 0, 0, 0);

    // Out-of-range coefficient index is ignored.
    write_coef(0, 6, 1234);
    write_coef(2, 7, -999);
    send_sample(321, 1, 321, 0, 0, 0, 0, 0, 0);

    // Randomized coefficients and samples.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int sec, idx, val;
        sec = $urandom_range(0, NSEC - 1);
        idx = $urandom_range(0, 7);
        if (idx == 3)      val = $urandom_range(0, 16384) - 8192;
        else if (idx == 4) val = $urandom_range(0, 8192) - 4096;
        else               val = $urandom_range(0, 32768) - 16384;
        write_coef(sec, idx, val);
      end
      send_sample($urandom_range(0, 65535) - 32768, 0, 0,
                  ($urandom_range(0, 7) == 0), 0, 0, 0, 0,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
    end

    // Reset in the middle of a computation.
    @(negedge clk);
    in_data = DW'(555); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    rst_n = 1'b1;
    for (cnt = 0; cnt < 30; cnt++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midcalc_no_valid", seen, 0);
    chk("midcalc_busy", busy, 0);
    chk("midcalc_sat", sat_flag, 0);
    send_sample(123, 1, 123, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iir_biquad_cascade.md
Name: iir_biquad_cascade

Overview:
Parametrised cascade of NSEC direct-form-II biquad IIR sections with run-time-writable coefficients. One shared multiplier-accumulator is time-multiplexed over every section and tap. Samples enter and leave through valid/ready handshakes. It sits in the DSP datapath between the sample source and downstream consumers.

Parameters:
DW, 16, sample width (signed two's complement)
CW, 16, coefficient width (signed, fixed point)
FRAC, 14, coefficient fractional bits (Q2.14 at defaults)
NSEC, 4, number of cascaded biquad sections (1..16)
ACCW, 40, accumulator width; must be >= DW+CW+3

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DW  input sample
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_data  out  DW  filtered sample
coef_we  in  1  coefficient write strobe
coef_sec  in  clog2(NSEC) (min 1)  target section
coef_idx  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 ignored
coef_wdata  in  CW  coefficient value
clear_state  in  1  zero all delay lines
busy  out  1  high while not IDLE
sat_flag  out  1  sticky saturation indicator

Behaviour:
- Reset: clk rising-edge design; rst_n asynchronous, active-low. Reset clears FSM to IDLE, all w1/w2 delay registers to 0, out_data=0, out_valid=0, busy=0, sat_flag=0, in_ready=1. Per section: b0=1<<FRAC, all other coefficients 0 (pass-through).
- Section math, per section s with input x: w = sat(((x<<FRAC) - a1*w1 - a2*w2) >>> FRAC); y = sat((b0*w + b1*w1 + b2*w2) >>> FRAC). Then w2<=w1, w1<=w. The y of section s is the x of section s+1. The final y is out_data.
- Shifts are arithmetic, truncate toward -inf. sat() clamps to [-2^(DW-1), 2^(DW-1)-1]. Any clamp sets sat_flag (sticky, cleared only by reset).
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_data, set s=0, tap=0, go to CALC.
  - CALC: one multiply-accumulate per cycle, 5 cycles per section:
    - tap0: acc = x<<FRAC - a1*w1
    - tap1: acc -= a2*w2; w formed
    - tap2: acc = b0*w
    - tap3: acc += b1*w1
    - tap4: acc += b2*w2; y formed; delay line updated
  - After tap4 of section NSEC-1, register out_data and go to OUT.
  - OUT: out_valid=1, out_data stable. On out_ready, go to IDLE. in_ready is 0 in CALC and OUT.
- Latency: accept edge to out_valid high = 5*NSEC+1 cycles. Throughput is one sample per 5*NSEC+2 cycles with out_ready held high.
- Coefficient writes act only in IDLE. Writes in other states, or with coef_idx>4, or with coef_sec>=NSEC, are dropped silently.
- clear_state acts only in IDLE. It zeros all w1/w2 on that edge. If in_valid is high on the same edge, the new sample is accepted and computed with zero state.
- Simultaneous coef_we and in_valid in IDLE: the write commits first; the accepted sample uses the new coefficient.
- Reset asserted mid-CALC or mid-OUT: computation is discarded, no out_valid pulse, everything returns to reset values.
- busy = (state != IDLE).

Test Plan:
- Reset pass-through: NSEC=4, in_data=1000 -> out_valid exactly 21 cycles after accept, out_data=1000; inputs -32768 and 32767 pass unchanged, sat_flag=0.
- Gain: write sec0 b0=8192 (0.5), in_data=1000 -> out_data=500. Then in_data=-1001 -> out_data=-501 (floor truncation).
- Recursion: sec0 a1=-8192 (w=x+0.5*w1), others pass-through; feed 16384, 0, 0, 0 -> outputs 16384, 8192, 4096, 2048. Then clear_state, feed 0 -> output 0.
- Saturation: sec0 b0=32767 (~2.0), in_data=30000 -> out_data=32767, sat_flag=1. Flag stays 1 on later small samples and clears only on reset.
- Backpressure and write gating: hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0, and a coef_we issued during this wait has no effect (verified on the next sample).
- Reset mid-CALC: pulse rst_n low at cycle 7 of CALC -> no out_valid, coefficients return to pass-through, next sample 123 -> 123.
